// File: rtl/csr_pkg.sv
// Shared CSR definitions: funct3 op encodings, operation decode, counter addresses, read-only prefix.
package csr_pkg;

  localparam int CSR_ADDR_W = 12;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Addresses whose top two bits match this prefix are read-only.
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE     = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET   = 12'hC02;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRETH  = 12'hC82;

  function automatic csr_op_e decode_op(input logic [2:0] funct3);
    case (funct3)
      F3_CSRRW, F3_CSRRWI: decode_op = CSR_OP_RW;
      F3_CSRRS, F3_CSRRSI: decode_op = CSR_OP_RS;
      F3_CSRRC, F3_CSRRCI: decode_op = CSR_OP_RC;
      default:             decode_op = CSR_OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free-running hardware counter split into two CSR-visible halves; a half write
// replaces that half of the incremented value at the same edge.
module csr_counter64 #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              wr_lo,
  input  logic              wr_hi,
  input  logic [DATA_W-1:0] wdata,
  output logic [CNT_W-1:0]  value
);

  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path can infer a latch.
    value_d = value_q + CNT_W'(inc);
    if (wr_lo) value_d[DATA_W-1:0]     = wdata;
    if (wr_hi) value_d[CNT_W-1:DATA_W] = wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value_q <= '0;
    else      value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/csr_exec_unit.sv
// Execute-stage CSR unit: decode, read-modify-write, forwarding and a registered write pulse.
// Define CSR_HW_COUNTERS_EN to add the mcycle/minstret counters and their read-only mirrors.
module csr_exec_unit
  import csr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = CSR_ADDR_W,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic              ex_flush,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_csr_addr,
  input  logic [4:0]        ex_rs1_idx,
  input  logic [DATA_W-1:0] ex_rs1_data,
  input  logic              instr_retire,
  output logic [ADDR_W-1:0] csr_rd_addr,
  input  logic [DATA_W-1:0] csr_rd_data,
  output logic [DATA_W-1:0] csr_old_value,
  output logic              illegal_csr,
  output logic              csr_write_en,
  output logic [ADDR_W-1:0] csr_wb_addr,
  output logic [DATA_W-1:0] csr_wb_data
);

  csr_op_e           op;
  logic [DATA_W-1:0] src, old_val, new_val;
  logic              wr_req, fwd_hit, issue;

  logic              csr_write_en_q, csr_write_en_d;
  logic [ADDR_W-1:0] csr_wb_addr_q, csr_wb_addr_d;
  logic [DATA_W-1:0] csr_wb_data_q, csr_wb_data_d;

  logic              cnt_hit;
  logic [DATA_W-1:0] cnt_rdata;

`ifdef CSR_HW_COUNTERS_EN
  logic [CNT_W-1:0] mcycle, minstret;

  csr_counter64 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (csr_write_en_q && csr_wb_addr_q == CSR_MCYCLE),
    .wr_hi (csr_write_en_q && csr_wb_addr_q == CSR_MCYCLEH),
    .wdata (csr_wb_data_q),
    .value (mcycle)
  );

  csr_counter64 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_retire),
    .wr_lo (csr_write_en_q && csr_wb_addr_q == CSR_MINSTRET),
    .wr_hi (csr_write_en_q && csr_wb_addr_q == CSR_MINSTRETH),
    .wdata (csr_wb_data_q),
    .value (minstret)
  );

  always_comb begin
    cnt_hit   = 1'b1;
    cnt_rdata = '0;
    case (ex_csr_addr)
      CSR_MCYCLE,    CSR_CYCLE:    cnt_rdata = mcycle[DATA_W-1:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   cnt_rdata = mcycle[CNT_W-1:DATA_W];
      CSR_MINSTRET,  CSR_INSTRET:  cnt_rdata = minstret[DATA_W-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: cnt_rdata = minstret[CNT_W-1:DATA_W];
      default:                     cnt_hit   = 1'b0;
    endcase
  end
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
  assign cnt_hit       = 1'b0;
  assign cnt_rdata     = '0;
`endif

  always_comb begin
    op     = decode_op(ex_funct3);
    src    = ex_funct3[2] ? DATA_W'(ex_rs1_idx) : ex_rs1_data;
    wr_req = (op == CSR_OP_RW) || ((op != CSR_OP_NONE) && (ex_rs1_idx != 5'd0));

    illegal_csr = ex_valid && ((op == CSR_OP_NONE) ||
                  (wr_req && ex_csr_addr[ADDR_W-1 -: 2] == CSR_RO_PREFIX));

    // A write still in flight to the file is newer than anything the file returns.
    fwd_hit = csr_write_en_q && (csr_wb_addr_q == ex_csr_addr);
    if (fwd_hit)      old_val = csr_wb_data_q;
    else if (cnt_hit) old_val = cnt_rdata;
    else              old_val = csr_rd_data;

    case (op)
      CSR_OP_RS: new_val = old_val | src;
      CSR_OP_RC: new_val = old_val & ~src;
      default:   new_val = src;
    endcase

    issue          = ex_valid && !ex_stall && !ex_flush && wr_req && !illegal_csr;
    csr_write_en_d = issue;
    csr_wb_addr_d  = issue ? ex_csr_addr : csr_wb_addr_q;
    csr_wb_data_d  = issue ? new_val     : csr_wb_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csr_write_en_q <= 1'b0;
      csr_wb_addr_q  <= '0;
      csr_wb_data_q  <= '0;
    end else begin
      csr_write_en_q <= csr_write_en_d;
      csr_wb_addr_q  <= csr_wb_addr_d;
      csr_wb_data_q  <= csr_wb_data_d;
    end
  end

  assign csr_rd_addr   = ex_csr_addr;
  assign csr_old_value = old_val;
  assign csr_write_en  = csr_write_en_q;
  assign csr_wb_addr   = csr_wb_addr_q;
  assign csr_wb_data   = csr_wb_data_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Bench for csr_exec_unit: vector table, hand-written corner sequences and a randomized
// phase checked against an architectural CSR-state model.
module tb_csr_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_stall, ex_flush, instr_retire;
  logic [2:0]  ex_funct3;
  logic [11:0] ex_csr_addr, csr_rd_addr, csr_wb_addr;
  logic [4:0]  ex_rs1_idx;
  logic [31:0] ex_rs1_data, csr_rd_data, csr_old_value, csr_wb_data;
  logic        illegal_csr, csr_write_en;

  csr_exec_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_stall     (ex_stall),
    .ex_flush     (ex_flush),
    .ex_funct3    (ex_funct3),
    .ex_csr_addr  (ex_csr_addr),
    .ex_rs1_idx   (ex_rs1_idx),
    .ex_rs1_data  (ex_rs1_data),
    .instr_retire (instr_retire),
    .csr_rd_addr  (csr_rd_addr),
    .csr_rd_data  (csr_rd_data),
    .csr_old_value(csr_old_value),
    .illegal_csr  (illegal_csr),
    .csr_write_en (csr_write_en),
    .csr_wb_addr  (csr_wb_addr),
    .csr_wb_data  (csr_wb_data)
  );

  always #5 clk = ~clk;

  // CSR register file: combinational read, negedge write; bench preloads share the port.
  logic [31:0] csr_file [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(negedge clk) begin
    if (csr_write_en)  csr_file[csr_wb_addr] <= csr_wb_data;
    else if (pl_en)    csr_file[pl_addr]     <= pl_data;
  end
  assign csr_rd_data = csr_file[csr_rd_addr];

  int n_vec = 0;
  int n_bad = 0;

  // Architectural CSR contents as seen by successive instructions.
  logic [31:0] ref_csr [4096];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [11:0] a,
                       input logic [4:0] idx, input logic [31:0] d,
                       input logic st, input logic fl);
    @(posedge clk); #1;
    ex_valid = v; ex_funct3 = f3; ex_csr_addr = a;
    ex_rs1_idx = idx; ex_rs1_data = d; ex_stall = st; ex_flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk); #1;
    pl_en = 1'b0;
    ref_csr[a] = d;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        valid;
    logic        flush;
    logic        chk_old;
    logic [31:0] old;
    logic        ill;
    logic        we;
    logic [31:0] wdata;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  logic [11:0] addr_list [6];

  // Randomized-phase variables
  logic        r_v, r_st, r_fl, r_wr, r_none, e_ill, pend, found;
  logic [2:0]  r_f3;
  logic [11:0] r_a, pa;
  logic [4:0]  r_idx;
  logic [31:0] r_d, r_src, r_old, r_new, pd;

  initial begin
    rst = 1'b1;
    {ex_valid, ex_stall, ex_flush, instr_retire} = '0;
    ex_funct3 = '0; ex_csr_addr = '0; ex_rs1_idx = '0; ex_rs1_data = '0;
    #2 rst = 1'b0;
    #1;
    check("reset_we",   csr_write_en, 0);
    check("reset_addr", csr_wb_addr,  0);
    check("reset_data", csr_wb_data,  0);

    preload(12'h300, 32'h11);
    preload(12'h305, 32'h0F);
    preload(12'h310, 32'h0000F0F0);
    preload(12'h340, 32'h0);
    @(negedge clk) rst = 1'b1;
    idle();

    // Back-to-back RS then RC on one CSR: second sees forwarded result.
    drive(1'b1, 3'b010, 12'h305, 5'd1, 32'hF0, 1'b0, 1'b0); settle();
    check("b2b_old1", csr_old_value, 32'h0F);
    drive(1'b1, 3'b011, 12'h305, 5'd2, 32'h30, 1'b0, 1'b0); settle();
    check("b2b_old2_fwd", csr_old_value, 32'hFF);
    check("b2b_we1",      csr_write_en,  1);
    check("b2b_data1",    csr_wb_data,   32'hFF);
    idle(); settle();
    check("b2b_we2",   csr_write_en, 1);
    check("b2b_addr2", csr_wb_addr,  32'h305);
    check("b2b_data2", csr_wb_data,  32'hCF);
    idle();

    //          f3      addr     idx    data           v     fl    chk   old            ill   we    wdata
    tbl[0]  = '{3'b001, 12'h300, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'h11,       1'b0, 1'b1, 32'hDEADBEEF};
    tbl[1]  = '{3'b010, 12'h310, 5'd3,  32'h00000F0F, 1'b1, 1'b0, 1'b1, 32'h0000F0F0, 1'b0, 1'b1, 32'h0000FFFF};
    tbl[2]  = '{3'b011, 12'h310, 5'd3,  32'h000000FF, 1'b1, 1'b0, 1'b1, 32'h0000FFFF, 1'b0, 1'b1, 32'h0000FF00};
    tbl[3]  = '{3'b110, 12'h300, 5'd0,  32'h0000FFFF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{3'b111, 12'h300, 5'd15, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEE0};
    tbl[5]  = '{3'b101, 12'h305, 5'd31, 32'h0,        1'b1, 1'b0, 1'b1, 32'hCF,       1'b0, 1'b1, 32'h1F};
    tbl[6]  = '{3'b000, 12'h300, 5'd1,  32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEE0, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{3'b100, 12'h300, 5'd1,  32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEE0, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{3'b110, 12'hC00, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    tbl[9]  = '{3'b001, 12'hC00, 5'd1,  32'h5,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[10] = '{3'b001, 12'h300, 5'd1,  32'h5,        1'b1, 1'b1, 1'b1, 32'hDEADBEE0, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{3'b010, 12'h305, 5'd0,  32'h0000FFFF, 1'b1, 1'b0, 1'b1, 32'h1F,       1'b0, 1'b0, 32'h0};
    tbl[12] = '{3'b001, 12'h300, 5'd1,  32'h5,        1'b0, 1'b0, 1'b1, 32'hDEADBEE0, 1'b0, 1'b0, 32'h0};
    tbl[13] = '{3'b011, 12'hC80, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    tbl[14] = '{3'b001, 12'hFFF, 5'd2,  32'h1,        1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[15] = '{3'b010, 12'h340, 5'd4,  32'h000000A5, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 32'hA5};

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].valid, tbl[i].f3, tbl[i].addr, tbl[i].idx, tbl[i].data, 1'b0, tbl[i].flush);
      settle();
      check($sformatf("t%0d_illegal", i), illegal_csr, tbl[i].ill);
      if (tbl[i].chk_old) check($sformatf("t%0d_old", i), csr_old_value, tbl[i].old);
      idle(); settle();
      check($sformatf("t%0d_we", i), csr_write_en, tbl[i].we);
      if (tbl[i].we) begin
        check($sformatf("t%0d_addr", i), csr_wb_addr, tbl[i].addr);
        check($sformatf("t%0d_data", i), csr_wb_data, tbl[i].wdata);
      end
    end

    // Stall for three cycles, then release: exactly one pulse.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b001, 12'h342, 5'd1, 32'h77, 1'b1, 1'b0); settle();
      check("stall_no_we", csr_write_en, 0);
    end
    drive(1'b1, 3'b001, 12'h342, 5'd1, 32'h77, 1'b0, 1'b0); settle();
    check("stall_release_we0", csr_write_en, 0);
    idle(); settle();
    check("stall_pulse_we",   csr_write_en, 1);
    check("stall_pulse_addr", csr_wb_addr,  32'h342);
    check("stall_pulse_data", csr_wb_data,  32'h77);
    idle(); settle();
    check("stall_pulse_end", csr_write_en, 0);

    // A pending write drains while the following op is stalled.
    drive(1'b1, 3'b001, 12'h343, 5'd1, 32'h99, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 12'h343, 5'd1, 32'h1, 1'b1, 1'b0); settle();
    check("drain_we",   csr_write_en,  1);
    check("drain_data", csr_wb_data,   32'h99);
    check("drain_fwd",  csr_old_value, 32'h99);
    idle(); settle();
    check("drain_stalled_no_we", csr_write_en, 0);

    // Randomized phase against the architectural model.
    addr_list[0] = 12'h300; addr_list[1] = 12'h301; addr_list[2] = 12'h305;
    addr_list[3] = 12'h340; addr_list[4] = 12'hC01; addr_list[5] = 12'h7C0;
    for (int i = 0; i < 6; i++) preload(addr_list[i], $urandom);
    idle(); idle();
    pend = 1'b0; pa = '0; pd = '0;
    for (int n = 0; n < 400; n++) begin
      r_v   = ($urandom_range(3) != 0);
      r_f3  = 3'($urandom_range(7));
      r_a   = addr_list[$urandom_range(5)];
      r_idx = ($urandom_range(2) == 0) ? 5'd0 : 5'($urandom_range(31));
      r_d   = $urandom;
      r_st  = ($urandom_range(4) == 0);
      r_fl  = ($urandom_range(6) == 0);
      drive(r_v, r_f3, r_a, r_idx, r_d, r_st, r_fl);
      settle();
      r_src  = r_f3[2] ? {27'd0, r_idx} : r_d;
      r_none = (r_f3[1:0] == 2'b00);
      r_wr   = (r_f3[1:0] == 2'b01) || (!r_none && r_idx != 5'd0);
      e_ill  = r_v && (r_none || (r_wr && r_a[11:10] == 2'b11));
      r_old  = ref_csr[r_a];
      case (r_f3[1:0])
        2'b01:   r_new = r_src;
        2'b10:   r_new = r_old | r_src;
        default: r_new = r_old & ~r_src;
      endcase
      check("rnd_illegal", illegal_csr, e_ill);
      if (r_v) check("rnd_old", csr_old_value, r_old);
      check("rnd_we", csr_write_en, pend);
      if (pend) begin
        check("rnd_addr", csr_wb_addr, pa);
        check("rnd_data", csr_wb_data, pd);
      end
      pend = r_v && !r_st && !r_fl && r_wr && !e_ill;
      if (pend) begin
        pa = r_a; pd = r_new; ref_csr[r_a] = r_new;
      end
    end
    idle(); settle();
    check("rnd_final_we", csr_write_en, pend);
    idle();

`ifdef CSR_HW_COUNTERS_EN
    // mcycle low half near wrap; high half must pick up the carry.
    drive(1'b1, 3'b001, 12'hB00, 5'd1, 32'hFFFFFFFE, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 12'hB80, 5'd1, 32'h0, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      drive(1'b1, 3'b110, 12'hB80, 5'd0, 32'h0, 1'b0, 1'b0); settle();
      if (csr_old_value == 32'h1) found = 1'b1;
    end
    check("mcycleh_carry", found, 1);
    drive(1'b1, 3'b110, 12'hC00, 5'd0, 32'h0, 1'b0, 1'b0); settle();
    check("cycle_lo_mirror", csr_old_value, 32'h1);
    drive(1'b1, 3'b110, 12'hC80, 5'd0, 32'h0, 1'b0, 1'b0); settle();
    check("cycleh_mirror", csr_old_value, 32'h1);

    drive(1'b1, 3'b110, 12'hB02, 5'd0, 32'h0, 1'b0, 1'b0); settle();
    check("minstret_start", csr_old_value, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle(); instr_retire = 1'b1;
    end
    idle(); instr_retire = 1'b0;
    drive(1'b1, 3'b110, 12'hB02, 5'd0, 32'h0, 1'b0, 1'b0); settle();
    check("minstret_plus4", csr_old_value, 32'h4);
    drive(1'b1, 3'b110, 12'hC82, 5'd0, 32'h0, 1'b0, 1'b0); settle();
    check("instreth_mirror", csr_old_value, 32'h0);
    idle();
`endif

    // Reset asserted during a write-enable cycle drops the write at once.
    drive(1'b1, 3'b001, 12'h344, 5'd1, 32'h55, 1'b0, 1'b0);
    idle(); settle();
    check("mid_rst_pre_we", csr_write_en, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_we",   csr_write_en, 0);
    check("mid_rst_addr", csr_wb_addr,  0);
    check("mid_rst_data", csr_wb_data,  0);
`ifdef CSR_HW_COUNTERS_EN
    ex_valid = 1'b1; ex_funct3 = 3'b110; ex_csr_addr = 12'hB00; ex_rs1_idx = 5'd0;
    #1;
    check("mid_rst_mcycle", csr_old_value, 32'h0);
    ex_csr_addr = 12'hB02;
    #1;
    check("mid_rst_minstret", csr_old_value, 32'h0);
`endif
    @(negedge clk) rst = 1'b1;
    idle(); settle();
    check("post_rst_we", csr_write_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
